// File: rtl/timer_scheduler.sv
// timer_scheduler: one shared countdown timer granted round-robin among N_REQ requesters.
// Optional per-requester abort input is compiled in with `define TIMER_SCHED_ABORT_EN.
module timer_scheduler #(
    parameter int N_REQ = 4,
    parameter int WIDTH = 8,
    parameter int ID_W  = $clog2(N_REQ)
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    // req[i] is a level valid, grant[i] the one-cycle accept: the requester holds req[i]
    // and its req_count slice until it sees grant[i], then drops req[i] the cycle after.
    input  logic [N_REQ-1:0]       req,
    input  logic [N_REQ*WIDTH-1:0] req_count,
`ifdef TIMER_SCHED_ABORT_EN
    input  logic [N_REQ-1:0]       abort,
`endif
    output logic [N_REQ-1:0]       grant,
    output logic [N_REQ-1:0]       expire,
    output logic                   busy,
    output logic [ID_W-1:0]        active_id,
    output logic [WIDTH-1:0]       remaining
);

    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [ID_W-1:0]  id_q, id_d;
    logic [ID_W-1:0]  ptr_q, ptr_d;
    logic [N_REQ-1:0] grant_q, grant_d;
    logic [N_REQ-1:0] expire_q, expire_d;

    logic [ID_W-1:0]  scan_idx;
    logic [ID_W-1:0]  sel;
    logic             sel_vld;
    logic [WIDTH-1:0] sel_cnt;
    logic             abort_hit;

    // Scan starts one past the last grant, so the requester just served ranks last.
    always_comb begin
        scan_idx = ptr_q;
        sel      = ptr_q;
        sel_vld  = 1'b0;
        for (int k = 0; k < N_REQ; k++) begin
            if (scan_idx == ID_W'(N_REQ - 1)) begin
                scan_idx = '0;
            end else begin
                scan_idx = scan_idx + 1'b1;
            end
            if (!sel_vld && req[scan_idx]) begin
                sel     = scan_idx;
                sel_vld = 1'b1;
            end
        end
    end

    always_comb begin
        sel_cnt = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (sel == ID_W'(i)) begin
                sel_cnt = req_count[i*WIDTH +: WIDTH];
            end
        end
    end

`ifdef TIMER_SCHED_ABORT_EN
    assign abort_hit = abort[id_q];
`else
    assign abort_hit = 1'b0;
`endif

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        id_d     = id_q;
        ptr_d    = ptr_q;
        grant_d  = '0;
        expire_d = '0;
        case (state_q)
            IDLE: begin
                if (sel_vld) begin
                    cnt_d        = sel_cnt;
                    id_d         = sel;
                    ptr_d        = sel;
                    grant_d[sel] = 1'b1;
                    state_d      = RUN;
                end
            end
            RUN: begin
                // Abort takes priority over a terminal count; the counter freezes where it was.
                if (abort_hit) begin
                    state_d = IDLE;
                end else if (cnt_q == '0) begin
                    expire_d[id_q] = 1'b1;
                    state_d        = IDLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            id_q     <= '0;
            ptr_q    <= ID_W'(N_REQ - 1);
            grant_q  <= '0;
            expire_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            id_q     <= id_d;
            ptr_q    <= ptr_d;
            grant_q  <= grant_d;
            expire_q <= expire_d;
        end
    end

    assign grant     = grant_q;
    assign expire    = expire_q;
    assign busy      = (state_q == RUN);
    assign active_id = id_q;
    assign remaining = cnt_q;

endmodule

// File: tb/tb_timer_scheduler.sv
// Bench for timer_scheduler: directed scenarios plus random traffic, all checked against
// a timeline model that predicts grant/expire cycles from delays and round-robin order.
module tb_timer_scheduler;
    localparam int N_REQ = 4;
    localparam int WIDTH = 8;
    localparam int ID_W  = 2;

    logic                   clk_i = 1'b0;
    logic                   rst_i;
    logic [N_REQ-1:0]       req;
    logic [N_REQ*WIDTH-1:0] req_count;
    logic [N_REQ-1:0]       grant, expire;
    logic                   busy;
    logic [ID_W-1:0]        active_id;
    logic [WIDTH-1:0]       remaining;
    logic [N_REQ-1:0]       abort_nxt;
`ifdef TIMER_SCHED_ABORT_EN
    logic [N_REQ-1:0]       abort;
`endif

    timer_scheduler #(.N_REQ(N_REQ), .WIDTH(WIDTH), .ID_W(ID_W)) dut (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .req       (req),
        .req_count (req_count),
`ifdef TIMER_SCHED_ABORT_EN
        .abort     (abort),
`endif
        .grant     (grant),
        .expire    (expire),
        .busy      (busy),
        .active_id (active_id),
        .remaining (remaining)
    );

    // clock / reset
    always #5 clk_i = ~clk_i;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int n_vec = 0;
    int n_err = 0;

    // Model: cyc is the next cycle to be checked; one timer record (grant cycle, delay,
    // id, first non-busy cycle) plus the round-robin pointer and the first free edge.
    int cyc, m_g, m_c, m_id, m_end, m_rem_after, m_ptr, m_act, m_free;
    bit m_run;
    logic [31:0] exp_q[$];

    logic [N_REQ-1:0] pend_v, sticky;
    int  pend_c[N_REQ];
    int  sticky_c;
    bit  rand_en, rst_nxt;
    int  obs_gid[$], obs_gcyc[$], obs_ecyc[$];

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s cyc=%0d: got %0h expected %0h", tag, cyc, obs, exp);
        end
    endtask

    function automatic int rand_cnt();
        case ($urandom_range(0, 7))
            0:       return 0;
            1:       return (1 << WIDTH) - 1;
            default: return int'($urandom_range(1, 12));
        endcase
    endfunction

    task automatic raise(input int i, input int c);
        logic [31:0] cv;
        cv = c;
        req[i] = 1'b1;
        req_count[i*WIDTH +: WIDTH] = cv[WIDTH-1:0];
    endtask

    task automatic post(input int i, input int c);
        pend_v[i] = 1'b1;
        pend_c[i] = c;
    endtask

    // One clock: check the current cycle, then drive and predict the next edge.
    task automatic tick();
        logic [N_REQ-1:0] g_exp, e_exp;
        logic [31:0] head;
        int rem_exp, n, sel, c;
        bit busy_exp, found;
        @(negedge clk_i);
        g_exp = '0;
        e_exp = '0;
        if (m_run && m_g == cyc) g_exp[m_id] = 1'b1;
        busy_exp = m_run && (cyc < m_end);
        rem_exp  = busy_exp ? m_c - (cyc - m_g) : m_rem_after;
        if (exp_q.size() > 0) begin
            head = exp_q[0];
            if (int'(head[31:4]) == cyc) begin
                e_exp[head[3:0]] = 1'b1;
                void'(exp_q.pop_front());
            end
        end
        check_eq("grant", 32'(grant), 32'(g_exp));
        check_eq("expire", 32'(expire), 32'(e_exp));
        check_eq("busy", 32'(busy), 32'(busy_exp));
        check_eq("active_id", 32'(active_id), m_act);
        check_eq("remaining", 32'(remaining), rem_exp);
        for (int i = 0; i < N_REQ; i++) begin
            if (grant[i]) begin obs_gid.push_back(i); obs_gcyc.push_back(cyc); end
            if (expire[i]) obs_ecyc.push_back(cyc);
        end

        n = cyc + 1;
        rst_i = rst_nxt;
        for (int i = 0; i < N_REQ; i++) begin
            if (rst_nxt) req[i] = 1'b0;
            else if (req[i] && g_exp[i]) req[i] = 1'b0;
            else if (!req[i]) begin
                if (pend_v[i]) begin raise(i, pend_c[i]); pend_v[i] = 1'b0; end
                else if (sticky[i]) raise(i, sticky_c);
                else if (rand_en && $urandom_range(0, 5) == 0) raise(i, rand_cnt());
            end
        end
`ifdef TIMER_SCHED_ABORT_EN
        abort = abort_nxt;
`endif

        if (rst_nxt) begin
            m_run = 0; m_act = 0; m_ptr = N_REQ - 1; m_rem_after = 0;
            exp_q.delete();
            m_free = n + 1;
        end else begin
`ifdef TIMER_SCHED_ABORT_EN
            if (m_run && abort_nxt[m_id] && n > m_g && n <= m_end) begin
                m_rem_after = m_c - (n - 1 - m_g);
                m_end  = n;
                m_free = n + 1;
                void'(exp_q.pop_back());
            end
`endif
            if (n >= m_free && req != '0) begin
                found = 0;
                sel = 0;
                for (int k = 1; k <= N_REQ; k++) begin
                    if (!found && req[(m_ptr + k) % N_REQ]) begin
                        sel = (m_ptr + k) % N_REQ;
                        found = 1;
                    end
                end
                c = int'(req_count[sel*WIDTH +: WIDTH]);
                m_run = 1; m_g = n; m_c = c; m_id = sel; m_end = n + c + 1;
                m_rem_after = 0; m_ptr = sel; m_act = sel; m_free = n + c + 2;
                exp_q.push_back({28'(n + c + 1), 4'(sel)});
            end
        end
        abort_nxt = '0;
        cyc = n;
    endtask

    task automatic run_idle(input int limit);
        int k;
        k = 0;
        while ((m_run && cyc <= m_end) || req != '0 || pend_v != '0) begin
            if (k == limit) begin
                check_eq("idle_timeout", k, limit + 1);
                return;
            end
            tick();
            k++;
        end
    endtask

    task automatic tick_until_grant(input int limit);
        int k;
        k = 0;
        while (!(m_run && m_g == cyc)) begin
            if (k == limit) begin
                check_eq("grant_timeout", k, limit + 1);
                return;
            end
            tick();
            k++;
        end
    endtask

    task automatic pulse_reset();
        rst_nxt = 1;
        tick();
        rst_nxt = 0;
        tick();
    endtask

    task automatic clear_obs();
        obs_gid.delete(); obs_gcyc.delete(); obs_ecyc.delete();
    endtask

    task automatic check_rr(input string tag);
        check_eq({tag, "_count"}, obs_gid.size(), 4);
        for (int k = 0; k < obs_gid.size() && k < 4; k++) check_eq({tag, "_order"}, obs_gid[k], k);
        for (int k = 1; k < obs_gcyc.size() && k < 4; k++)
            check_eq({tag, "_period"}, obs_gcyc[k] - obs_gcyc[k-1], 3);
    endtask

    initial begin
        rst_i = 1'b1; req = '0; req_count = '0; abort_nxt = '0;
`ifdef TIMER_SCHED_ABORT_EN
        abort = '0;
`endif
        pend_v = '0; sticky = '0; sticky_c = 0; rand_en = 0; rst_nxt = 0;
        repeat (2) @(negedge clk_i);
        rst_i = 1'b0;
        cyc = 1; m_run = 0; m_act = 0; m_ptr = N_REQ - 1; m_rem_after = 0; m_free = 0;
        m_g = 0; m_c = 0; m_id = 0; m_end = 0;
        repeat (3) tick();

        // single request, delay 5
        clear_obs();
        post(0, 5);
        run_idle(100);
        check_eq("single_gcount", obs_gid.size(), 1);
        if (obs_gid.size() > 0 && obs_ecyc.size() > 0) begin
            check_eq("single_id", obs_gid[0], 0);
            check_eq("single_lat", obs_ecyc[0] - obs_gcyc[0], 6);
        end
        tick();

        // zero delay
        clear_obs();
        post(2, 0);
        run_idle(100);
        if (obs_gid.size() > 0 && obs_ecyc.size() > 0) begin
            check_eq("zero_id", obs_gid[0], 2);
            check_eq("zero_lat", obs_ecyc[0] - obs_gcyc[0], 1);
        end

        // round-robin from reset, then reissued
        pulse_reset();
        clear_obs();
        for (int i = 0; i < N_REQ; i++) post(i, 1);
        run_idle(200);
        check_rr("rr1");
        clear_obs();
        for (int i = 0; i < N_REQ; i++) post(i, 1);
        run_idle(200);
        check_rr("rr2");

        // fairness between two continuously re-requesting clients
        clear_obs();
        sticky = 4'b1001; sticky_c = 2;
        repeat (40) tick();
        sticky = '0;
        run_idle(200);
        check_eq("fair_count", 32'(obs_gid.size() >= 6), 1);
        for (int k = 0; k < obs_gid.size() && k < 6; k++)
            check_eq("fair_order", obs_gid[k], (k % 2 == 0) ? 0 : 3);

        // reset during a long run
        clear_obs();
        post(1, 200);
        tick_until_grant(50);
        repeat (10) tick();
        pulse_reset();
        repeat (250) tick();
        check_eq("rst_no_expire", obs_ecyc.size(), 0);
        clear_obs();
        for (int i = 0; i < N_REQ; i++) post(i, 0);
        run_idle(200);
        if (obs_gid.size() > 0) check_eq("rst_first_id", obs_gid[0], 0);

`ifdef TIMER_SCHED_ABORT_EN
        clear_obs();
        post(1, 10);
        tick_until_grant(50);
        repeat (3) tick();
        abort_nxt[1] = 1'b1;
        tick();
        run_idle(100);
        check_eq("abort_no_expire", obs_ecyc.size(), 0);

        clear_obs();
        post(1, 10);
        tick_until_grant(50);
        repeat (6) begin abort_nxt = 4'b0100; tick(); end
        run_idle(100);
        check_eq("abort_other_expire", obs_ecyc.size(), 1);

        clear_obs();
        post(1, 10);
        tick_until_grant(50);
        repeat (10) tick();
        abort_nxt[1] = 1'b1;
        tick();
        run_idle(100);
        check_eq("abort_at_zero", obs_ecyc.size(), 0);
`endif

        // random traffic with occasional resets
        rand_en = 1;
        repeat (3000) begin
            rst_nxt = ($urandom_range(0, 699) == 0);
            tick();
        end
        rand_en = 0;
        rst_nxt = 0;
        run_idle(2000);
        repeat (3) tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/timer_scheduler.md
# timer_scheduler

Time-multiplexes a single countdown timer between `N_REQ` requesters. Each requester posts a delay; the block grants one request at a time, round-robin, counts it down, and pulses a per-requester expiry. It sits between client FSMs and the shared countdown resource, so that one counter serves many slow timeouts.

## Interface

**Parameters**
- `N_REQ`, default 4: number of requesters; legal values are ≥ 2.
- `WIDTH`, default 8: width of a delay count.
- `ID_W`, default `$clog2(N_REQ)`: width of a requester index.

**Ports**
- `clk_i`  in  1: clock.
- `rst_i`  in  1: synchronous, active-high reset.
- `req`  in  `N_REQ`: level request, one bit per requester.
- `req_count`  in  `N_REQ*WIDTH`: requested delay; slice `i` is `[i*WIDTH +: WIDTH]`.
- `abort`  in  `N_REQ`: cancel the active timer. Present only with `TIMER_SCHED_ABORT_EN`.
- `grant`  out  `N_REQ`: one-hot, one-cycle pulse; the request is accepted.
- `expire`  out  `N_REQ`: one-hot, one-cycle pulse; the delay has elapsed.
- `busy`  out  1: timer occupied (state RUN).
- `active_id`  out  `ID_W`: index of the current or last granted requester.
- `remaining`  out  `WIDTH`: current counter value.

## Operation

- Two states: IDLE and RUN. All outputs are registered.
- **IDLE**
  - If `req != 0` at an edge, select the first set bit at or after `ptr+1`, wrapping modulo `N_REQ`.
  - Load `cnt <= req_count[sel]`, `active_id <= sel`, `ptr <= sel`, `grant[sel] <= 1`, then go to RUN.
  - If no request is set, stay in IDLE.
- **RUN**
  - `req` is ignored.
  - At each edge: if `cnt == 0`, set `expire[active_id] <= 1` and go to IDLE; otherwise `cnt <= cnt - 1`.
- **Requester contract**
  - Hold `req[i]` and its `req_count` slice stable until `grant[i]` is seen.
  - Deassert `req[i]` in the cycle after `grant[i]`.
  - If `req[i]` is still high when the block returns to IDLE, it is treated as a new request.
- **Arithmetic**
  - `cnt` is `WIDTH` bits and only decrements while nonzero, so it never wraps.
  - `req_count = 0` is legal and gives minimum latency.
- **Round-robin**
  - A requester that was just served has the lowest priority at the next arbitration.
  - No requester waits more than `N_REQ-1` other grants.
- **Reset**
  - State goes to IDLE. `grant`, `expire`, `busy`, `active_id`, `remaining` are all 0; `ptr = N_REQ-1`, so requester 0 has first priority.
  - Reset during RUN drops the active timer; no `expire` is produced.

## Timing

- Edge E0 (IDLE, request present) → `grant[i]` high in cycle E0..E1; `busy` rises in the same cycle.
- Delay C → `expire[i]` is high in cycle E(C+1)..E(C+2). That is C+1 cycles after the grant cycle; C = 0 gives expiry in the cycle immediately after grant.
- `busy` falls in the same cycle that `expire` is high.
- The next grant can occur on the edge that ends the expire cycle, giving back-to-back throughput of one timer per C+2 cycles.
- `remaining` equals `cnt`: C in the grant cycle, counting down to 0 in the cycle before expire.
- `grant` and `expire` are never both high for the same index in the same cycle.

## Configuration

- **`TIMER_SCHED_ABORT_EN` defined**
  - The `abort` port exists.
  - In RUN, if `abort[active_id]` is high at an edge, go to IDLE with no `expire`.
  - Abort wins over a simultaneous `cnt == 0`.
  - `abort` bits for non-active indices, and any `abort` in IDLE, are ignored.
- **Not defined**
  - The `abort` port is absent.
  - Every granted timer runs to `expire` unless `rst_i` is asserted.

## Test plan

- **Single request.** `N_REQ=4`, `WIDTH=8`; `req=0001`, `req_count[0]=5` → `grant=0001` for one cycle; `remaining` goes 5,4,3,2,1,0; `expire=0001` exactly 6 cycles after grant; `busy` is low the cycle after expire.
- **Zero delay.** `req[2]` with count 0 → `grant[2]`, then `expire[2]` on the very next cycle.
- **Round-robin.** `req=1111` held with all counts 1, each requester dropping its `req` after its grant → grant order 0,1,2,3; period 3 cycles; reissue all four → order 0,1,2,3 again.
- **Fairness.** `req[0]` and `req[3]` re-requested continuously after each expire → grants alternate 0,3,0,3.
- **Reset mid-run.** Count 200, `rst_i` pulsed 10 cycles after grant → no `expire` ever; `busy=0` and `remaining=0` the cycle after reset; the next request goes to index 0.
- **Abort (`TIMER_SCHED_ABORT_EN`).** Count 10 on index 1:
  - `abort[1]` after 4 cycles → no `expire`, `busy` drops.
  - `abort[2]` during the run of index 1 → ignored; `expire[1]` on time.
  - `abort[1]` coincident with `cnt == 0` → no `expire`.
